io_responder: RTL and testbench

Memory-mapped I/O responder sitting on the processor's data bus, the peripheral end of the KEY/SW/HEX/LEDR/LEDG address window at 0xF0000000. It decodes load/store addresses from the core, returns switch and key data, and drives the LEDs and 7-segment displays. Inputs are synchronized and debounced, and change events are latched into sticky ready/overrun status bits so software can poll them.

---
 rtl/io_pkg.sv | 43 ++++
 rtl/io_debouncer.sv | 54 +++++
 rtl/io_responder.sv | 146 ++++++++++++++
 tb/tb_io_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the KEY/SW/HEX/LEDR/LEDG I/O window.
//   - Register byte addresses inside the 0xF0000xxx page.
//   - Bit positions of the ready/overrun flags in KCTRL/SCTRL.
//   - hex_to_seg: 4-bit value to active-low 7-segment pattern (gfedcba).
package io_pkg;

    localparam logic [19:0] IO_PAGE    = 20'hF0000;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
    localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

    localparam int unsigned STAT_READY   = 0;
    localparam int unsigned STAT_OVERRUN = 2;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_debouncer.sv
// io_debouncer: 2-flop synchronizer, stability counter and commit register
// for one group of raw inputs.
//   clk, reset : system clock, synchronous active-high reset
//   raw_in     : asynchronous input vector
//   value      : committed (debounced) vector
//   commit     : high for the cycle in which value is about to update
module io_debouncer #(
    parameter int unsigned WIDTH           = 4,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000,
    parameter int unsigned CNT_BITS        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] value,
    output logic             commit
);

    localparam logic [CNT_BITS-1:0] CNT_DONE = CNT_BITS'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0]    sync1;
    logic [WIDTH-1:0]    sync2;
    logic [WIDTH-1:0]    last;
    logic [CNT_BITS-1:0] cnt;

    // cnt holds how many cycles sync2 has kept its current value; it is
    // reloaded with 1 on the first cycle of a new value and parks at CNT_DONE.
    assign commit = (sync2 == last) && (sync2 != value) && (cnt == CNT_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            last  <= '0;
            value <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            last  <= sync2;
            if (commit) begin
                value <= sync2;
                cnt   <= '0;
            end else if (sync2 == value) begin
                cnt <= '0;
            end else if (sync2 != last) begin
                cnt <= CNT_BITS'(1);
            end else if (cnt != CNT_DONE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped KEY/SW/HEX/LEDR/LEDG peripheral at 0xF0000xxx.
//   clk, reset        : system clock, synchronous active-high reset
//   addr, rdEn, wrtEn : bus address and one-cycle load/store strobes
//   dataIn / dataOut  : store data / combinational load data (0 when unselected)
//   sel               : addr lies in the 0xF0000xxx page
//   KEY, SW           : raw buttons (active-low) and switches
//   LEDR, LEDG        : LED registers
//   HEX0..HEX3        : 7-segment outputs, active-low
// Optional macro IO_HEX_DECODE_EN: decode the HEX register onto HEX0..HEX3;
// without it the displays stay blank (7'h7F) but the register still reads back.
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned DBITS           = 32,
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000,
    parameter int unsigned CNT_BITS        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wrtEn,
    input  logic             rdEn,
    input  logic [DBITS-1:0] dataIn,
    output logic [DBITS-1:0] dataOut,
    output logic             sel,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    logic [3:0]  key_val;
    logic        key_commit;
    logic [9:0]  sw_val;
    logic        sw_commit;
    logic [15:0] hex_reg;
    logic        k_ready, k_ovr, s_ready, s_ovr;
    logic [9:0]  word;
    logic        rd_key, rd_sw, clr_kovr, clr_sovr;
    logic        unused_bits;

    io_debouncer #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS(CNT_BITS)
    ) u_key_db (
        .clk(clk),
        .reset(reset),
        .raw_in(~KEY),
        .value(key_val),
        .commit(key_commit)
    );

    io_debouncer #(
        .WIDTH(10),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS(CNT_BITS)
    ) u_sw_db (
        .clk(clk),
        .reset(reset),
        .raw_in(SW),
        .value(sw_val),
        .commit(sw_commit)
    );

    assign sel      = (addr[31:12] == IO_PAGE);
    assign word     = addr[11:2];
    assign rd_key   = rdEn  && sel && (word == ADDR_KEY[11:2]);
    assign rd_sw    = rdEn  && sel && (word == ADDR_SW[11:2]);
    assign clr_kovr = wrtEn && sel && (word == ADDR_KCTRL[11:2]) && !dataIn[STAT_OVERRUN];
    assign clr_sovr = wrtEn && sel && (word == ADDR_SCTRL[11:2]) && !dataIn[STAT_OVERRUN];

    assign unused_bits = ^{addr[1:0], dataIn[DBITS-1:16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_reg <= '0;
            LEDR    <= '0;
            LEDG    <= '0;
        end else if (wrtEn && sel) begin
            case (word)
                ADDR_HEX[11:2]:  hex_reg <= dataIn[15:0];
                ADDR_LEDR[11:2]: LEDR    <= dataIn[9:0];
                ADDR_LEDG[11:2]: LEDG    <= dataIn[7:0];
                default: ;
            endcase
        end
    end

    // A commit always wins over a same-cycle read: the read returns the old
    // value and the new one stays pending, so ready stays set and the commit
    // is not counted as an overrun. A commit onto a still-pending value sets
    // overrun even if software is clearing it in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_ready <= 1'b0;
            k_ovr   <= 1'b0;
            s_ready <= 1'b0;
            s_ovr   <= 1'b0;
        end else begin
            k_ready <= key_commit || (k_ready && !rd_key);
            k_ovr   <= (key_commit && k_ready && !rd_key) || (k_ovr && !clr_kovr);
            s_ready <= sw_commit || (s_ready && !rd_sw);
            s_ovr   <= (sw_commit && s_ready && !rd_sw) || (s_ovr && !clr_sovr);
        end
    end

    always_comb begin
        dataOut = '0;
        if (sel && rdEn) begin
            case (word)
                ADDR_HEX[11:2]:  dataOut[15:0] = hex_reg;
                ADDR_LEDR[11:2]: dataOut[9:0]  = LEDR;
                ADDR_LEDG[11:2]: dataOut[7:0]  = LEDG;
                ADDR_KEY[11:2]:  dataOut[3:0]  = key_val;
                ADDR_SW[11:2]:   dataOut[9:0]  = sw_val;
                ADDR_KCTRL[11:2]: begin
                    dataOut[STAT_READY]   = k_ready;
                    dataOut[STAT_OVERRUN] = k_ovr;
                end
                ADDR_SCTRL[11:2]: begin
                    dataOut[STAT_READY]   = s_ready;
                    dataOut[STAT_OVERRUN] = s_ovr;
                end
                default: dataOut = '0;
            endcase
        end
    end

`ifdef IO_HEX_DECODE_EN
    assign HEX0 = hex_to_seg(hex_reg[3:0]);
    assign HEX1 = hex_to_seg(hex_reg[7:4]);
    assign HEX2 = hex_to_seg(hex_reg[11:8]);
    assign HEX3 = hex_to_seg(hex_reg[15:12]);
`else
    assign HEX0 = '1;
    assign HEX1 = '1;
    assign HEX2 = '1;
    assign HEX3 = '1;
`endif

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: scoreboard bench for io_responder (DEBOUNCE_CYCLES = 8).
// The driver pushes the expected load data for every read it issues; a
// negedge monitor pops and compares whenever rdEn is high, and also checks
// the LED/HEX outputs against the reference model every cycle.
module tb_io_responder;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, dataIn, dataOut;
    logic        wrtEn, rdEn, sel;
    logic [3:0]  KEY;
    logic [9:0]  SW, LEDR;
    logic [7:0]  LEDG;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    always #5 clk = ~clk;

    io_responder #(
        .DBITS(32),
        .DEBOUNCE_CYCLES(32'd8),
        .CNT_BITS(4)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn), .rdEn(rdEn),
        .dataIn(dataIn), .dataOut(dataOut), .sel(sel), .KEY(KEY), .SW(SW),
        .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        sel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_kval;
    logic [9:0]  m_sval;
    bit          m_krdy, m_kovr, m_srdy, m_sovr;
    logic [9:0]  hist_s[$];
    logic [9:0]  hist_k[$];
    logic [9:0]  cur_sw;
    logic [3:0]  cur_key;

    logic [31:0] addrs [10] = '{32'hF000_0000, 32'hF000_0004, 32'hF000_0008, 32'hF000_000C,
                                32'hF000_0010, 32'hF000_0014, 32'hF000_0110, 32'hF000_0114,
                                32'hF000_0020, 32'h0000_0014};

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    function automatic logic [6:0] exp_hex(input logic [3:0] d);
        logic [6:0] s;
        s = seg(d);
`ifdef IO_HEX_DECODE_EN
        return s;
`else
        return (s == s) ? 7'h7F : 7'h00;
`endif
    endfunction

    // Input sampled at edge e reaches the debouncer two edges later; a value
    // commits at the edge where it has been seen unchanged for D+1 samples
    // (D stable cycles plus the commit register) and differs from the
    // committed one. h holds one input sample per edge, newest last, not yet
    // including the edge being evaluated.
    function automatic bit will_commit(input logic [9:0] h[$], input logic [9:0] cv);
        int n;
        logic [9:0] v;
        n = h.size();
        v = h[n-2];
        for (int k = 0; k <= D; k++)
            if (h[n-2-k] != v) return 1'b0;
        return v != cv;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:12] != 20'hF0000) return 32'h0;
        case ({a[31:2], 2'b00})
            32'hF000_0000: return {16'h0, m_hex};
            32'hF000_0004: return {22'h0, m_ledr};
            32'hF000_0008: return {24'h0, m_ledg};
            32'hF000_0010: return {28'h0, m_kval};
            32'hF000_0014: return {22'h0, m_sval};
            32'hF000_0110: return {29'h0, m_kovr, 1'b0, m_krdy};
            32'hF000_0114: return {29'h0, m_sovr, 1'b0, m_srdy};
            default:       return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_hex = '0; m_ledr = '0; m_ledg = '0; m_kval = '0; m_sval = '0;
        m_krdy = 0; m_kovr = 0; m_srdy = 0; m_sovr = 0;
        hist_s.delete(); hist_k.delete();
        for (int i = 0; i < D + 3; i++) begin
            hist_s.push_back('0);
            hist_k.push_back('0);
        end
    endtask

    task automatic model_edge();
        logic [31:0] w;
        bit cs, ck, rds, rdk, clrs, clrk;
        logic [9:0] ns, nk;
        w    = {addr[31:2], 2'b00};
        cs   = will_commit(hist_s, m_sval);
        ck   = will_commit(hist_k, {6'b0, m_kval});
        ns   = hist_s[hist_s.size()-2];
        nk   = hist_k[hist_k.size()-2];
        rds  = rdEn  && (w == 32'hF000_0014);
        rdk  = rdEn  && (w == 32'hF000_0010);
        clrs = wrtEn && (w == 32'hF000_0114) && !dataIn[2];
        clrk = wrtEn && (w == 32'hF000_0110) && !dataIn[2];
        if (cs) begin
            if (m_srdy && !rds) m_sovr = 1; else if (clrs) m_sovr = 0;
            m_srdy = 1; m_sval = ns;
        end else begin
            if (rds) m_srdy = 0;
            if (clrs) m_sovr = 0;
        end
        if (ck) begin
            if (m_krdy && !rdk) m_kovr = 1; else if (clrk) m_kovr = 0;
            m_krdy = 1; m_kval = nk[3:0];
        end else begin
            if (rdk) m_krdy = 0;
            if (clrk) m_kovr = 0;
        end
        if (wrtEn) begin
            case (w)
                32'hF000_0000: m_hex  = dataIn[15:0];
                32'hF000_0004: m_ledr = dataIn[9:0];
                32'hF000_0008: m_ledg = dataIn[7:0];
                default: ;
            endcase
        end
        hist_s.push_back(SW);
        hist_k.push_back({6'b0, ~KEY});
        while (hist_s.size() > 40) begin
            void'(hist_s.pop_front());
            void'(hist_k.pop_front());
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h at %0t", nm, got, want, $time);
        end
    endtask

    // One bus cycle: op 0 idle, 1 load, 2 store. Called at posedge+1.
    task automatic step(input int op, input logic [31:0] a, input logic [31:0] d,
                        input bit use_c, input logic [31:0] c, input string nm);
        exp_t e;
        SW = cur_sw; KEY = cur_key; addr = a; dataIn = d;
        rdEn = (op == 1); wrtEn = (op == 2);
        if (op == 1) begin
            e.name = nm;
            e.data = use_c ? c : model_read(a);
            e.sel  = (a[31:12] == 20'hF0000);
            sb.push_back(e);
        end
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
        rdEn = 0; wrtEn = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 0, 32'h0, "");
    endtask
    task automatic rd(input logic [31:0] a, input string nm);
        step(1, a, 32'h0, 0, 32'h0, nm);
    endtask
    task automatic rdc(input logic [31:0] a, input logic [31:0] c, input string nm);
        step(1, a, 32'h0, 1, c, nm);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(2, a, d, 0, 32'h0, "");
    endtask

    always @(negedge clk) begin
        if (rdEn) begin
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_data"}, dataOut, mon_e.data);
                chk({mon_e.name, "_sel"}, {31'h0, sel}, {31'h0, mon_e.sel});
            end
        end
        chk("LEDR", {22'h0, LEDR}, {22'h0, m_ledr});
        chk("LEDG", {24'h0, LEDG}, {24'h0, m_ledg});
        chk("HEX0", {25'h0, HEX0}, {25'h0, exp_hex(m_hex[3:0])});
        chk("HEX1", {25'h0, HEX1}, {25'h0, exp_hex(m_hex[7:4])});
        chk("HEX2", {25'h0, HEX2}, {25'h0, exp_hex(m_hex[11:8])});
        chk("HEX3", {25'h0, HEX3}, {25'h0, exp_hex(m_hex[15:12])});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int unsigned r;
        bit found;
        reset = 1; addr = '0; dataIn = '0; rdEn = 0; wrtEn = 0;
        cur_sw = 10'h3FF; cur_key = 4'hF; SW = cur_sw; KEY = cur_key;
        model_reset();
        @(posedge clk); #1;

        // Reset with switches held high; commit lands exactly 3+D edges later.
        idle(4);
        reset = 0;
        rdc(32'hF000_0114, 32'h0, "rst_sctrl");
        rdc(32'hF000_0014, 32'h0, "rst_sdata");
        idle(D);
        rdc(32'hF000_0114, 32'h0, "sctrl_before_commit");
        rdc(32'hF000_0114, 32'h1, "sctrl_after_commit");
        rdc(32'hF000_0014, 32'h3FF, "sdata_3ff");
        rdc(32'hF000_0114, 32'h0, "sctrl_cleared");

        // Register writes and read-back, address aliasing, unmapped space.
        wr(32'hF000_0000, 32'h0000_1234);
        rdc(32'hF000_0000, 32'h1234, "hex_rb");
        wr(32'hF000_0004, 32'hFFFF_FFFF);
        rdc(32'hF000_0004, 32'h3FF, "ledr_rb");
        wr(32'hF000_000A, 32'h0000_01A5);
        rdc(32'hF000_0009, 32'hA5, "ledg_rb");
        wr(32'hF000_0020, 32'hFFFF_FFFF);
        rdc(32'hF000_0020, 32'h0, "unmapped_rd");
        rdc(32'hF000_0004, 32'h3FF, "ledr_after_unmapped");
        rdc(32'hF000_0000, 32'h1234, "hex_after_unmapped");
        rdc(32'h0000_0004, 32'h0, "outside_window");

        // Bouncing switch never commits; a stable one does.
        for (int i = 0; i < 10; i++) begin
            cur_sw = (i % 2 == 1) ? 10'h001 : 10'h000;
            idle(3);
        end
        rdc(32'hF000_0114, 32'h0, "bounce_no_commit");
        cur_sw = 10'h005;
        idle(14);
        rdc(32'hF000_0114, 32'h1, "sctrl_005");
        rdc(32'hF000_0014, 32'h005, "sdata_005");

        // Load of SDATA in the same cycle as a commit.
        cur_sw = 10'h006;
        idle(14);
        cur_sw = 10'h00A;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (will_commit(hist_s, m_sval)) begin
                rdc(32'hF000_0014, 32'h006, "sdata_at_commit");
                found = 1;
            end else begin
                idle(1);
            end
        end
        chk("commit_window_found", {31'h0, found}, 32'h1);
        rdc(32'hF000_0114, 32'h1, "sctrl_pending");
        rdc(32'hF000_0014, 32'h00A, "sdata_00a");
        rdc(32'hF000_0114, 32'h0, "sctrl_consumed");

        // KEY press then release without reading: overrun.
        cur_key = 4'b1110;
        idle(14);
        cur_key = 4'b1111;
        idle(14);
        rdc(32'hF000_0110, 32'h5, "kctrl_overrun");
        rdc(32'hF000_0010, 32'h0, "kdata_released");
        rdc(32'hF000_0110, 32'h4, "kctrl_after_read");
        wr(32'hF000_0110, 32'h0);
        rdc(32'hF000_0110, 32'h0, "kctrl_cleared");

        // Reset in the middle of a debounce discards the pending change.
        cur_sw = 10'h155;
        idle(5);
        reset = 1;
        idle(2);
        reset = 0;
        rdc(32'hF000_0014, 32'h0, "sdata_after_midreset");
        rdc(32'hF000_0000, 32'h0, "hex_after_midreset");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) cur_sw = 10'($urandom);
            if ($urandom_range(0, 24) == 0) cur_key = 4'($urandom);
            r = $urandom_range(0, 9);
            a = addrs[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
            if (r < 5)      idle(1);
            else if (r < 8) rd(a, "rand_read");
            else            wr(a, $urandom);
        end

        idle(2);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
